// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and the IF/ID register layout used by the
// fetch/decode boundary.
package pipeline_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
   localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;

   // Field of a J-type instruction that forms the jump target word index.
   localparam int JT_HI = 25;
   localparam int JT_LO = 0;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc_plus4;
      logic            valid;
   } if_id_t;

endpackage

// File: rtl/fetch_decode_stage_if.sv
// Instruction-memory bus between the fetch stage and the instruction memory.
interface fetch_decode_stage_if;
   import pipeline_pkg::*;

   // The master presents imem_addr every cycle. imem_rdata is accepted only in a
   // cycle where imem_ready=1; when it is low the master keeps the same address
   // and retries, and imem_rdata is ignored.
   logic [XLEN-1:0] imem_addr;
   logic [XLEN-1:0] imem_rdata;
   logic            imem_ready;

   modport master (
      output imem_addr,
      input  imem_rdata,
      input  imem_ready
   );

   modport slave (
      input  imem_addr,
      output imem_rdata,
      output imem_ready
   );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds while disabled, loads a bubble on clear,
// otherwise captures the fetched instruction.
module if_id_reg #(
   parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   en,
   input  logic                   clr,
   input  logic [31:0]            instr_in,
   input  logic [31:0]            pc_plus4_in,
   output pipeline_pkg::if_id_t   q
);
   import pipeline_pkg::*;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q.instr    <= NOP_INSTR;
         q.pc_plus4 <= '0;
         q.valid    <= 1'b0;
      end else if (en) begin
         if (clr) begin
            q.instr    <= NOP_INSTR;
            q.pc_plus4 <= '0;
            q.valid    <= 1'b0;
         end else begin
            q.instr    <= instr_in;
            q.pc_plus4 <= pc_plus4_in;
            q.valid    <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/fetch_decode_stage.sv
// Fetch stage: PC register, next-PC selection (sequential/branch/jump) and the
// IF/ID pipeline register feeding decode.
module fetch_decode_stage #(
   parameter logic [31:0] RESET_PC  = pipeline_pkg::RESET_PC,
   parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        stall_f,
   input  logic                        stall_d,
   input  logic                        jump_d,
   input  logic                        pc_src_d,
   input  logic [31:0]                 branch_target_d,
   fetch_decode_stage_if.master        imem,
   output logic [31:0]                 instr_d,
   output logic [31:0]                 pc_plus4_d,
   output logic                        valid_d
);
   import pipeline_pkg::*;

   logic [XLEN-1:0] pc_f;
   logic [XLEN-1:0] pc_plus4_f;
   logic [XLEN-1:0] pc_next;
   logic [XLEN-1:0] jump_tgt;
   logic [XLEN-1:0] branch_tgt;
   logic            redirect;
   if_id_t          if_id;

   // Decode's branch operands are not valid while it is stalled, so its
   // redirect request is meaningless until the stall clears.
   assign redirect   = (jump_d | pc_src_d) & ~stall_d;
   assign pc_plus4_f = pc_f + 32'd4;
   assign jump_tgt   = {if_id.pc_plus4[31:28], if_id.instr[JT_HI:JT_LO], 2'b00};
   assign branch_tgt = branch_target_d & ~32'h3;

   always_comb begin
      pc_next = pc_f;
      if (stall_f) begin
         pc_next = pc_f;
      end else if (redirect && jump_d) begin
         pc_next = jump_tgt;
      end else if (redirect) begin
         pc_next = branch_tgt;
      end else if (!imem.imem_ready) begin
         pc_next = pc_f;
      end else begin
         pc_next = pc_plus4_f;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_f <= RESET_PC;
      end else begin
         pc_f <= pc_next;
      end
   end

   assign imem.imem_addr = pc_f;

   if_id_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id_reg (
      .clk         (clk),
      .reset_n     (reset_n),
      .en          (~stall_d),
      .clr         (redirect | ~imem.imem_ready),
      .instr_in    (imem.imem_rdata),
      .pc_plus4_in (pc_plus4_f),
      .q           (if_id)
   );

   assign instr_d    = if_id.instr;
   assign pc_plus4_d = if_id.pc_plus4;
   assign valid_d    = if_id.valid;

endmodule
